// File: rtl/sfx_pkg.sv
// Shared types, effect note tables and the saturating adder for the sound-effect player.
package sfx_pkg;

  localparam int SAMPLE_W  = 24;
  localparam int MAX_NOTES = 4;

  typedef enum logic [1:0] {
    FX_NONE  = 2'd0,
    FX_FLAP  = 2'd1,
    FX_SCORE = 2'd2,
    FX_DIE   = 2'd3
  } fx_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  typedef struct packed {
    logic [7:0]  half_period;
    logic [15:0] duration;
  } note_t;

  // Both fields are counted in sample ticks; unused slots are zero padding.
  localparam note_t FLAP_NOTES [MAX_NOTES] = '{
    '{8'd48, 16'd2400}, '{8'd32, 16'd2400}, '{8'd0, 16'd0}, '{8'd0, 16'd0}
  };
  localparam note_t SCORE_NOTES [MAX_NOTES] = '{
    '{8'd24, 16'd4800}, '{8'd18, 16'd9600}, '{8'd0, 16'd0}, '{8'd0, 16'd0}
  };
  localparam note_t DIE_NOTES [MAX_NOTES] = '{
    '{8'd60, 16'd7200}, '{8'd80, 16'd7200}, '{8'd100, 16'd7200}, '{8'd120, 16'd7200}
  };

  // Indexed by fx_e.
  localparam logic [2:0] NOTE_COUNT [MAX_NOTES] = '{3'd0, 3'd2, 3'd2, 3'd4};

  function automatic note_t note_of(input fx_e fx, input logic [1:0] idx);
    note_t n;
    n = '0;
    case (fx)
      FX_FLAP:  n = FLAP_NOTES[idx];
      FX_SCORE: n = SCORE_NOTES[idx];
      FX_DIE:   n = DIE_NOTES[idx];
      default:  n = '0;
    endcase
    return n;
  endfunction

  // Adds at one extra bit and clamps to the representable signed range.
  function automatic logic signed [SAMPLE_W-1:0] sat_add(
    input logic signed [SAMPLE_W-1:0] a,
    input logic signed [SAMPLE_W-1:0] b
  );
    logic signed [SAMPLE_W:0] sum;
    sum = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
    if (sum[SAMPLE_W] != sum[SAMPLE_W-1])
      return sum[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
    return sum[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/sfx_player_sq_tone.sv
// Square-wave phase generator: toggles polarity every half_period sample ticks.
module sq_tone
  import sfx_pkg::*;
(
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick,
  input  logic       restart,
  input  logic [7:0] half_period,
  output logic       polarity
);

  logic [7:0] phase;

  // NOTE: clocked state is always written with <= so every register samples
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge CLOCK_50) begin
    if (reset || restart) begin
      phase    <= '0;
      polarity <= 1'b1;
    end else if (tick) begin
      if (phase == 8'(half_period - 8'd1)) begin
        phase    <= '0;
        polarity <= ~polarity;
      end else begin
        phase <= phase + 8'd1;
      end
    end
  end

endmodule

// File: rtl/sfx_player.sv
// Sound-effect sequencer and mixer feeding the audio codec write port.
module sfx_player
  import sfx_pkg::*;
#(
  parameter int                     W   = SAMPLE_W,
  parameter logic signed [W-1:0]    AMP = 24'sd1048576
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                trig_flap,
  input  logic                trig_score,
  input  logic                trig_die,
  input  logic                mute,
  input  logic signed [W-1:0] in_left,
  input  logic signed [W-1:0] in_right,
  input  logic                write_ready,
  output logic                write,
  output logic signed [W-1:0] writedata_left,
  output logic signed [W-1:0] writedata_right,
  output logic                busy,
  output logic [1:0]          cur_fx
);

  state_e      state_q, state_d;
  fx_e         fx_q, fx_d, req;
  logic [1:0]  note_idx, idx_d;
  logic [15:0] dur_cnt, dur_d;
  note_t       note;
  logic        tick, note_end, last_note, start, polarity;
  logic signed [W-1:0] tone;

  assign write  = write_ready & ~reset;
  assign busy   = (state_q == ST_PLAY);
  assign cur_fx = fx_q;

  assign note      = note_of(fx_q, note_idx);
  assign tick      = write_ready && (state_q == ST_PLAY);
  assign note_end  = tick && (dur_cnt == 16'(note.duration - 16'd1));
  assign last_note = (3'(note_idx) + 3'd1) == NOTE_COUNT[fx_q];

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    req = FX_NONE;
    if (trig_die)        req = FX_DIE;
    else if (trig_score) req = FX_SCORE;
    else if (trig_flap)  req = FX_FLAP;
  end

  // A trigger on the final tick always wins, even at lower priority.
  assign start = (req != FX_NONE) &&
                 ((state_q == ST_IDLE) || (req >= fx_q) || (note_end && last_note));

  always_comb begin
    state_d = state_q;
    fx_d    = fx_q;
    idx_d   = note_idx;
    dur_d   = dur_cnt;
    if (start) begin
      state_d = ST_PLAY;
      fx_d    = req;
      idx_d   = '0;
      dur_d   = '0;
    end else if (tick) begin
      if (note_end) begin
        dur_d = '0;
        if (last_note) begin
          state_d = ST_IDLE;
          fx_d    = FX_NONE;
          idx_d   = '0;
        end else begin
          idx_d = note_idx + 2'd1;
        end
      end else begin
        dur_d = dur_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      fx_q     <= FX_NONE;
      note_idx <= '0;
      dur_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      fx_q     <= fx_d;
      note_idx <= idx_d;
      dur_cnt  <= dur_d;
    end
  end

  sq_tone u_tone (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .tick        (tick),
    .restart     (start || note_end),
    .half_period (note.half_period),
    .polarity    (polarity)
  );

  always_comb begin
    tone = '0;
    if ((state_q == ST_PLAY) && !mute) tone = polarity ? AMP : -AMP;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      writedata_left  <= '0;
      writedata_right <= '0;
    end else begin
      writedata_left  <= sat_add(in_left, tone);
      writedata_right <= sat_add(in_right, tone);
    end
  end

endmodule

// File: tb/tb_sfx_player.sv
// Scoreboard bench for sfx_player: a tick-count model predicts every output sample.
module tb_sfx_player;

  localparam int W     = 24;
  localparam int AMP_I = 1048576;
  localparam int SMAX  = 8388607;
  localparam int SMIN  = -8388608;

  // Rows indexed by effect (0 none, 1 flap, 2 score, 3 die).
  localparam int HALF [4][4] = '{'{0,0,0,0}, '{48,32,0,0}, '{24,18,0,0}, '{60,80,100,120}};
  localparam int DUR  [4][4] = '{'{0,0,0,0}, '{2400,2400,0,0}, '{4800,9600,0,0},
                                 '{7200,7200,7200,7200}};

  logic clk = 1'b0;
  logic reset, trig_flap, trig_score, trig_die, mute, write_ready;
  logic signed [W-1:0] in_left, in_right;
  logic write, busy;
  logic signed [W-1:0] writedata_left, writedata_right;
  logic [1:0] cur_fx;

  always #5 clk = ~clk;

  sfx_player dut (
    .CLOCK_50        (clk),
    .reset           (reset),
    .trig_flap       (trig_flap),
    .trig_score      (trig_score),
    .trig_die        (trig_die),
    .mute            (mute),
    .in_left         (in_left),
    .in_right        (in_right),
    .write_ready     (write_ready),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .busy            (busy),
    .cur_fx          (cur_fx)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic signed [31:0] actual,
                       input logic signed [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic signed [W-1:0] wl;
    logic signed [W-1:0] wr;
    logic                b;
    logic [1:0]          fx;
  } exp_t;

  exp_t sb[$];

  bit m_play;
  int m_fx;
  int m_t;

  function automatic int total_ticks(input int fx);
    int s = 0;
    for (int i = 0; i < 4; i++) s += DUR[fx][i];
    return s;
  endfunction

  // Polarity from elapsed ticks: which note we are in, then which half-cycle.
  function automatic bit pol_plus(input int fx, input int t);
    int off = t;
    for (int i = 0; i < 4; i++) begin
      if (off < DUR[fx][i]) return ((off / HALF[fx][i]) % 2) == 0;
      off -= DUR[fx][i];
    end
    return 1'b1;
  endfunction

  function automatic int sat_i(input int v);
    if (v > SMAX) return SMAX;
    if (v < SMIN) return SMIN;
    return v;
  endfunction

  // One clock: predict, push, clock, pop and compare.
  task automatic step();
    exp_t e;
    int   tone, req;
    bit   fin;
    #1;
    check("write", 32'(write), 32'(write_ready & ~reset));
    if (reset) begin
      e.wl = '0; e.wr = '0;
      m_play = 1'b0; m_fx = 0; m_t = 0;
    end else begin
      tone = (m_play && !mute) ? (pol_plus(m_fx, m_t) ? AMP_I : -AMP_I) : 0;
      e.wl = 24'(sat_i(int'(in_left) + tone));
      e.wr = 24'(sat_i(int'(in_right) + tone));
      req  = trig_die ? 3 : trig_score ? 2 : trig_flap ? 1 : 0;
      fin  = m_play && write_ready && (m_t + 1 == total_ticks(m_fx));
      if (req != 0 && (!m_play || req >= m_fx || fin)) begin
        m_play = 1'b1; m_fx = req; m_t = 0;
      end else if (m_play && write_ready) begin
        m_t++;
        if (m_t == total_ticks(m_fx)) begin
          m_play = 1'b0; m_fx = 0; m_t = 0;
        end
      end
    end
    e.b  = m_play;
    e.fx = 2'(m_fx);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("wd_left",  32'(writedata_left),  32'(e.wl));
    check("wd_right", 32'(writedata_right), 32'(e.wr));
    check("busy",     32'(busy),            32'(e.b));
    check("cur_fx",   32'(cur_fx),          32'(e.fx));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic pulse(input bit f, input bit s, input bit d);
    trig_flap = f; trig_score = s; trig_die = d;
    step();
    trig_flap = 1'b0; trig_score = 1'b0; trig_die = 1'b0;
  endtask

  int cnt, ticks;
  logic signed [W-1:0] held_wd;
  logic held_busy;

  initial begin
    reset = 1'b1; trig_flap = 1'b0; trig_score = 1'b0; trig_die = 1'b0;
    mute = 1'b0; write_ready = 1'b1; in_left = '0; in_right = '0;
    m_play = 1'b0; m_fx = 0; m_t = 0;

    // Reset state
    do_reset();
    check("rst_busy", 32'(busy), 0);
    check("rst_fx",   32'(cur_fx), 0);
    check("rst_wd",   32'(writedata_left), 0);

    // 1: flap with a sample tick every clock
    pulse(1'b1, 1'b0, 1'b0);
    check("flap_wd_latency", 32'(writedata_left), 0);
    check("flap_fx", 32'(cur_fx), 1);
    cnt = 1;
    step();
    check("flap_first_tone", 32'(writedata_left), AMP_I);
    if (busy) cnt++;
    for (int i = 0; i < 6000 && busy; i++) begin
      step();
      if (busy) cnt++;
    end
    check("flap_busy_ticks", cnt, 4800);
    check("flap_fx_end", 32'(cur_fx), 0);

    // 2: score with one tick every four clocks
    do_reset();
    ticks = 0;
    for (int c = 0; c < 70000; c++) begin
      write_ready = (c % 4 == 0);
      trig_score  = (c == 0);
      if (busy && write_ready) ticks++;
      step();
      if (c > 0 && !busy) break;
    end
    trig_score = 1'b0;
    write_ready = 1'b1;
    check("score_ticks", ticks, 14400);

    // 3: priority
    do_reset();
    pulse(1'b1, 1'b0, 1'b1);
    check("prio_same_cycle", 32'(cur_fx), 3);
    repeat (10) step();
    pulse(1'b0, 1'b1, 1'b0);
    check("die_ignores_score", 32'(cur_fx), 3);
    repeat (10) step();
    check("die_continues", 32'(busy), 1);
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    repeat (60) step();
    pulse(1'b0, 1'b1, 1'b0);
    check("flap_restart_score", 32'(cur_fx), 2);
    step();
    check("restart_pol_plus", 32'(writedata_left), AMP_I);

    // 4: saturation and mute
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    in_left = 24'sh7FFFF0; in_right = 24'sh7FFFF0;
    step();
    check("sat_pos", 32'(writedata_left), 32'(24'sh7FFFFF));
    in_left = '0; in_right = '0;
    repeat (47) step();
    in_left = 24'sh800010; in_right = 24'sh800010;
    step();
    check("sat_neg", 32'(writedata_right), 32'(24'sh800000));
    mute = 1'b1; in_left = 24'sh123456; in_right = -24'sd5000;
    step();
    check("mute_pass_l", 32'(writedata_left), 32'(24'sh123456));
    check("mute_pass_r", 32'(writedata_right), -5000);
    mute = 1'b0; in_left = '0; in_right = '0;

    // 5: reset mid-die, coincident trigger ignored
    do_reset();
    pulse(1'b0, 1'b0, 1'b1);
    repeat (999) step();
    reset = 1'b1; trig_flap = 1'b1;
    step();
    reset = 1'b0; trig_flap = 1'b0;
    check("rst_mid_busy", 32'(busy), 0);
    check("rst_mid_fx",   32'(cur_fx), 0);
    check("rst_mid_wd",   32'(writedata_left), 0);
    in_left = 24'sd12345; in_right = -24'sd777;
    step();
    check("post_rst_pass", 32'(writedata_left), 12345);
    check("post_rst_idle", 32'(busy), 0);
    in_left = '0; in_right = '0;

    // 6: write_ready held low mid-flap
    do_reset();
    ticks = 0;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 1000; i++) begin
      if (busy && write_ready) ticks++;
      step();
    end
    write_ready = 1'b0;
    step();
    held_wd = writedata_left;
    held_busy = busy;
    repeat (4999) step();
    check("hold_wd",   32'(writedata_left), 32'(held_wd));
    check("hold_busy", 32'(busy), 32'(held_busy));
    write_ready = 1'b1;
    for (int i = 0; i < 6000 && busy; i++) begin
      if (busy && write_ready) ticks++;
      step();
    end
    check("hold_total_ticks", ticks, 4800);
    check("hold_end_idle", 32'(busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
